ori_rr_share: RTL and testbench
===============================

# ori_rr_share

Round-robin sharing controller for a single bitwise-OR datapath, placed where several dataflow producers need OR operations but only one OR unit with one result register is instantiated. Each requester presents an lhs/rhs pair with independent valid/ready handshakes. The block joins each pair, grants one requester per cycle in rotating priority, and computes `lhs | rhs` into a one-slot output buffer. It returns the result on a shared data bus with a one-hot per-requester valid.

## Interface
- DATA_TYPE, 32: operand/result width in bits.
- NUM_REQ, 2: number of requesters, legal range 2..8.
- IDX_W, $clog2(NUM_REQ): width of the internal requester index and pointer (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- lhs  in  NUM_REQ*DATA_TYPE  operand A; requester i occupies bits [i*DATA_TYPE +: DATA_TYPE].
- lhs_valid  in  NUM_REQ  per-requester lhs valid.
- lhs_ready  out  NUM_REQ  per-requester lhs ready.
- rhs  in  NUM_REQ*DATA_TYPE  operand B, same packing as lhs.
- rhs_valid  in  NUM_REQ  per-requester rhs valid.
- rhs_ready  out  NUM_REQ  per-requester rhs ready.
- result  out  DATA_TYPE  buffered OR result, shared by all requesters.
- result_valid  out  NUM_REQ  one-hot; bit i means result belongs to requester i.
- result_ready  in  NUM_REQ  per-requester consumer ready.

## Operation
- Eligibility: req[i] = lhs_valid[i] & rhs_valid[i]. A requester with only one operand valid is never granted, and none of its ready outputs is asserted.
- State: full (1 bit), owner (IDX_W), data (DATA_TYPE), ptr (IDX_W).
- Drain: drain = full & result_ready[owner].
- Accept: can_accept = ~full | drain.
- Grant: the first eligible requester scanning ptr, ptr+1, …, NUM_REQ-1, 0, …, ptr-1.
  - Computed combinationally.
  - grant_any = can_accept & (|req).
- lhs_ready[g] = rhs_ready[g] = 1 only for the granted g when grant_any. All other bits are 0.
- Both operands of requester g are consumed together in the grant cycle.
- On the clock edge with grant_any:
  - data <= lhs[g] | rhs[g].
  - owner <= g.
  - full <= 1.
  - ptr <= (g+1) mod NUM_REQ. The wrap uses an explicit compare, not power-of-two truncation.
- On the clock edge with drain and no grant: full <= 0. data and owner hold.
- With no grant, ptr holds.
- result = data at all times.
- result_valid = full ? onehot(owner) : 0.
- Arithmetic: pure bitwise OR, width DATA_TYPE, no extension or truncation.
- Invariant: at most one bit of each ready vector and at most one bit of result_valid is high.

## Timing
- Latency: one cycle. An operand pair accepted at edge k produces its result with result_valid at cycle k+1.
- Throughput: one result per cycle when consumers are always ready. A simultaneous drain and grant in the same cycle is mandatory.
- Combinational paths:
  - result_ready → lhs_ready/rhs_ready (through drain).
  - lhs_valid/rhs_valid → ready.
  - No combinational path from inputs to result or result_valid.
- Backpressure:
  - While full and result_ready[owner]=0, all ready outputs are 0.
  - data, owner and result_valid hold stable.
  - result_ready of a non-owner requester is ignored.
- Handshake rules:
  - Requesters may deassert valid without a grant.
  - Consumers may toggle result_ready freely.
  - Valid is never gated by ready.
- Reset values, while rst is high and immediately after release:
  - full=0, owner=0, data=0, ptr=0.
  - result=0, result_valid=0, lhs_ready=0, rhs_ready=0.
  - Ready outputs are forced to 0 while rst is high, regardless of inputs.
- Reset mid-operation discards the buffered result without a handshake. Arbitration resumes from ptr=0 on the first edge after release.

## Test plan
- Single requester, NUM_REQ=2: req0 lhs=0x0000_00F0, rhs=0x0000_000F, result_ready=all 1 → lhs_ready[0]=rhs_ready[0]=1 for one cycle; next cycle result=0x0000_00FF, result_valid=2'b01; ptr=1.
- Round-robin fairness, NUM_REQ=4, all eligible continuously, all ready → grant order 0,1,2,3,0,…; result_valid walks 0001,0010,0100,1000 with back-to-back results every cycle; ptr wraps 3→0.
- Partial operand: req1 lhs_valid=1, rhs_valid=0 for 5 cycles, req0 idle → no ready bit asserted, result_valid stays 0; raising rhs_valid grants req1 that cycle.
- Backpressure: result held for requester 2 with result_ready[2]=0 for 3 cycles while req0/req1 wait → all readys 0, result stable. Asserting result_ready[2] drains and grants req0 (ptr=0 after the wrap from 3) in the same cycle. result_ready[0]=1 on an owner≠0 buffer is ignored.
- Non-power-of-two NUM_REQ=3, all eligible → grants 0,1,2,0; ptr never reaches 3.
- Async reset asserted mid-cycle while full with owner=1, data=0xDEADBEEF → result_valid and readys drop to 0 immediately, result=0. After release with req2 eligible, req2 is granted on the first edge (scan from ptr=0).

Source files
------------

// File: rtl/ori_rr_share.sv
// Round-robin sharing controller: several requesters time-share one OR unit
// whose result sits in a one-slot buffer tagged with the owning requester.
module ori_rr_share #(
  parameter int unsigned DATA_TYPE = 32,
  parameter int unsigned NUM_REQ   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ*DATA_TYPE-1:0] lhs,
  input  logic [NUM_REQ-1:0]           lhs_valid,
  output logic [NUM_REQ-1:0]           lhs_ready,
  input  logic [NUM_REQ*DATA_TYPE-1:0] rhs,
  input  logic [NUM_REQ-1:0]           rhs_valid,
  output logic [NUM_REQ-1:0]           rhs_ready,
  output logic [DATA_TYPE-1:0]         result,
  output logic [NUM_REQ-1:0]           result_valid,
  input  logic [NUM_REQ-1:0]           result_ready
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic                 full_q, full_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [DATA_TYPE-1:0] data_q, data_d;

  logic [NUM_REQ-1:0] req;
  logic               drain;
  logic               can_accept;
  logic               found;
  logic               grant_any;
  logic [IDX_W-1:0]   gnt_idx;
  logic [IDX_W:0]     scan_idx;
  logic [NUM_REQ-1:0] ready_vec;

  assign req        = lhs_valid & rhs_valid;
  assign drain      = full_q & result_ready[owner_q];
  assign can_accept = ~full_q | drain;

  // Rotating-priority scan starting at ptr; the wrap subtracts NUM_REQ so
  // non-power-of-two counts never alias onto an out-of-range index.
  always_comb begin
    found    = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, ptr_q} + (IDX_W + 1)'(k);
      if (scan_idx >= (IDX_W + 1)'(NUM_REQ)) begin
        scan_idx = scan_idx - (IDX_W + 1)'(NUM_REQ);
      end
      if (!found && req[scan_idx]) begin
        found   = 1'b1;
        gnt_idx = scan_idx[IDX_W-1:0];
      end
    end
  end

  assign grant_any = can_accept & found & ~rst;

  always_comb begin
    ready_vec = '0;
    if (grant_any) begin
      ready_vec[gnt_idx] = 1'b1;
    end
  end

  assign lhs_ready = ready_vec;
  assign rhs_ready = ready_vec;

  always_comb begin
    full_d  = full_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    if (grant_any) begin
      full_d  = 1'b1;
      owner_d = gnt_idx;
      data_d  = lhs[gnt_idx*DATA_TYPE +: DATA_TYPE] | rhs[gnt_idx*DATA_TYPE +: DATA_TYPE];
      ptr_d   = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end else if (drain) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q  <= 1'b0;
      owner_q <= '0;
      ptr_q   <= '0;
      data_q  <= '0;
    end else begin
      full_q  <= full_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
    end
  end

  assign result = data_q;

  always_comb begin
    result_valid = '0;
    if (full_q) begin
      result_valid[owner_q] = 1'b1;
    end
  end

endmodule

// File: tb/tb_ori_rr_share.sv
// Directed bench for ori_rr_share: a 4-requester and a 3-requester instance
// share clock and reset; expected values are hand-computed constants.
module tb_ori_rr_share;

  logic clk;
  logic rst;

  logic [127:0] lhs4, rhs4;
  logic [3:0]   lv4, rv4, lr4, rr4, resv4, resr4;
  logic [31:0]  res4;

  logic [95:0]  lhs3, rhs3;
  logic [2:0]   lv3, rv3, lr3, rr3, resv3, resr3;
  logic [31:0]  res3;

  int checks;
  int errors;

  ori_rr_share #(.DATA_TYPE(32), .NUM_REQ(4)) u4 (
    .clk(clk), .rst(rst),
    .lhs(lhs4), .lhs_valid(lv4), .lhs_ready(lr4),
    .rhs(rhs4), .rhs_valid(rv4), .rhs_ready(rr4),
    .result(res4), .result_valid(resv4), .result_ready(resr4)
  );

  ori_rr_share #(.DATA_TYPE(32), .NUM_REQ(3)) u3 (
    .clk(clk), .rst(rst),
    .lhs(lhs3), .lhs_valid(lv3), .lhs_ready(lr3),
    .rhs(rhs3), .rhs_valid(rv3), .rhs_ready(rr3),
    .result(res3), .result_valid(resv3), .result_ready(resr3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    lhs4 = '0; rhs4 = '0; lv4 = '0; rv4 = '0; resr4 = '1;
    lhs3 = '0; rhs3 = '0; lv3 = '0; rv3 = '0; resr3 = '1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    lv4 = '1; rv4 = '1; lv3 = '1; rv3 = '1;
    #2;
    checks++; if (lr4 !== 4'b0000 || rr4 !== 4'b0000) begin
      errors++; $display("FAIL reset_ready4 got %b/%b want 0000", lr4, rr4); end
    checks++; if (resv4 !== 4'b0000) begin
      errors++; $display("FAIL reset_valid4 got %b want 0000", resv4); end
    checks++; if (res4 !== 32'h0) begin
      errors++; $display("FAIL reset_result4 got %h want 0", res4); end
    tick();
    checks++; if (lr3 !== 3'b000 || resv3 !== 3'b000 || res3 !== 32'h0) begin
      errors++; $display("FAIL reset_u3 got %b %b %h want 000 000 0", lr3, resv3, res3); end
    clear_inputs();
    tick();
    rst = 1'b0;
    #1;
    checks++; if (lr4 !== 4'b0000 || resv4 !== 4'b0000 || res4 !== 32'h0) begin
      errors++; $display("FAIL reset_release got %b %b %h want 0000 0000 0", lr4, resv4, res4); end
  endtask

  task automatic test_single();
    do_reset();
    lhs4[31:0] = 32'h0000_00F0; rhs4[31:0] = 32'h0000_000F;
    lv4 = 4'b0001; rv4 = 4'b0001;
    #1;
    checks++; if (lr4 !== 4'b0001 || rr4 !== 4'b0001) begin
      errors++; $display("FAIL single_ready got %b/%b want 0001", lr4, rr4); end
    tick();
    lv4 = '0; rv4 = '0;
    #1;
    checks++; if (res4 !== 32'h0000_00FF || resv4 !== 4'b0001) begin
      errors++; $display("FAIL single_result got %h %b want 000000ff 0001", res4, resv4); end
    checks++; if (lr4 !== 4'b0000) begin
      errors++; $display("FAIL single_ready_drop got %b want 0000", lr4); end
    tick();
    checks++; if (resv4 !== 4'b0000 || res4 !== 32'h0000_00FF) begin
      errors++; $display("FAIL single_drain got %b %h want 0000 000000ff", resv4, res4); end
    // ptr moved to 1, so req1 beats req0
    lv4 = 4'b0011; rv4 = 4'b0011;
    #1;
    checks++; if (lr4 !== 4'b0010) begin
      errors++; $display("FAIL single_ptr got %b want 0010", lr4); end
    lv4 = '0; rv4 = '0;
  endtask

  task automatic test_round_robin();
    logic [3:0]  exp_oh;
    logic [31:0] exp_res;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      lhs4[i*32 +: 32] = 32'h1 << i;
      rhs4[i*32 +: 32] = 32'h100 << i;
    end
    lv4 = '1; rv4 = '1;
    for (int c = 0; c < 8; c++) begin
      exp_oh  = 4'b0001 << (c % 4);
      exp_res = (32'h1 << (c % 4)) | (32'h100 << (c % 4));
      #1;
      checks++; if (lr4 !== exp_oh) begin
        errors++; $display("FAIL rr_grant c=%0d got %b want %b", c, lr4, exp_oh); end
      tick();
      checks++; if (resv4 !== exp_oh || res4 !== exp_res) begin
        errors++; $display("FAIL rr_result c=%0d got %b %h want %b %h", c, resv4, res4,
                           exp_oh, exp_res); end
    end
    lv4 = '0; rv4 = '0;
  endtask

  task automatic test_partial();
    do_reset();
    lhs4[63:32] = 32'h1234_0000; rhs4[63:32] = 32'h0000_5678;
    lv4 = 4'b0010; rv4 = 4'b0000;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (lr4 !== 4'b0000 || rr4 !== 4'b0000 || resv4 !== 4'b0000) begin
        errors++; $display("FAIL partial_idle c=%0d got %b %b %b want 0", c, lr4, rr4, resv4); end
      tick();
    end
    rv4 = 4'b0010;
    #1;
    checks++; if (lr4 !== 4'b0010 || rr4 !== 4'b0010) begin
      errors++; $display("FAIL partial_grant got %b/%b want 0010", lr4, rr4); end
    tick();
    checks++; if (resv4 !== 4'b0010 || res4 !== 32'h1234_5678) begin
      errors++; $display("FAIL partial_result got %b %h want 0010 12345678", resv4, res4); end
    lv4 = '0; rv4 = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    lhs4[95:64] = 32'hA000_0000; rhs4[95:64] = 32'h0000_000A;
    lhs4[31:0]  = 32'h0000_0F00; rhs4[31:0]  = 32'h0000_00F0;
    lhs4[63:32] = 32'h5555_0000; rhs4[63:32] = 32'h0000_5555;
    resr4 = 4'b1011;
    lv4 = 4'b0100; rv4 = 4'b0100;
    tick();
    lv4 = 4'b0011; rv4 = 4'b0011;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (lr4 !== 4'b0000 || rr4 !== 4'b0000) begin
        errors++; $display("FAIL bp_ready c=%0d got %b/%b want 0000", c, lr4, rr4); end
      checks++; if (resv4 !== 4'b0100 || res4 !== 32'hA000_000A) begin
        errors++; $display("FAIL bp_hold c=%0d got %b %h want 0100 a000000a", c, resv4, res4); end
      tick();
    end
    resr4 = 4'b1111;
    #1;
    checks++; if (lr4 !== 4'b0001) begin
      errors++; $display("FAIL bp_drain_grant got %b want 0001", lr4); end
    tick();
    checks++; if (resv4 !== 4'b0001 || res4 !== 32'h0000_0FF0) begin
      errors++; $display("FAIL bp_next got %b %h want 0001 00000ff0", resv4, res4); end
    lv4 = '0; rv4 = '0;
  endtask

  task automatic test_nonpow2();
    logic [2:0] exp_oh;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      lhs3[i*32 +: 32] = 32'hC0 + i;
      rhs3[i*32 +: 32] = 32'h30;
    end
    lv3 = '1; rv3 = '1;
    for (int c = 0; c < 7; c++) begin
      exp_oh = 3'b001 << (c % 3);
      #1;
      checks++; if (lr3 !== exp_oh) begin
        errors++; $display("FAIL np2_grant c=%0d got %b want %b", c, lr3, exp_oh); end
      tick();
      checks++; if (resv3 !== exp_oh || res3 !== 32'hF0 + 32'(c % 3)) begin
        errors++; $display("FAIL np2_result c=%0d got %b %h want %b %h", c, resv3, res3,
                           exp_oh, 32'hF0 + 32'(c % 3)); end
    end
    lv3 = '0; rv3 = '0;
  endtask

  task automatic test_async_reset();
    do_reset();
    lhs4[63:32] = 32'hDEAD_0000; rhs4[63:32] = 32'h0000_BEEF;
    lv4 = 4'b0010; rv4 = 4'b0010;
    tick();
    checks++; if (resv4 !== 4'b0010 || res4 !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL ar_load got %b %h want 0010 deadbeef", resv4, res4); end
    lhs4[95:64] = 32'h0000_7700; rhs4[95:64] = 32'h0000_0077;
    lv4 = 4'b0100; rv4 = 4'b0100;
    resr4 = 4'b0000;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (resv4 !== 4'b0000 || res4 !== 32'h0 || lr4 !== 4'b0000 || rr4 !== 4'b0000) begin
      errors++; $display("FAIL ar_mid got %b %h %b/%b want 0000 0 0000", resv4, res4, lr4, rr4); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if (lr4 !== 4'b0100) begin
      errors++; $display("FAIL ar_rescan got %b want 0100", lr4); end
    tick();
    checks++; if (resv4 !== 4'b0100 || res4 !== 32'h0000_7777) begin
      errors++; $display("FAIL ar_after got %b %h want 0100 00007777", resv4, res4); end
    lv4 = '0; rv4 = '0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_partial();
    test_backpressure();
    test_nonpow2();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
